// File: rtl/cpu_pkg.sv
// Shared core definitions: 2-bit branch counter encodings and the saturating
// next-state function used by the branch history table.
package cpu_pkg;

    localparam logic [1:0] SNT     = 2'b00;
    localparam logic [1:0] WNT     = 2'b01;
    localparam logic [1:0] WT      = 2'b10;
    localparam logic [1:0] ST      = 2'b11;
    localparam logic [1:0] CNT_RST = WNT;

    function automatic logic [1:0] sat2_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != SNT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// One branch history table entry: 2-bit saturating counter, sync reset to weak-NT.
module sat_counter2
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic       taken,
    output logic [1:0] cnt
);

    logic [1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= CNT_RST;
        else if (we)
            r_cnt <= sat2_next(r_cnt, taken);
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/branch_predictor.sv
// Branch history table of 2-bit counters with misprediction flag and
// wrapping branch/mispredict statistics.
module branch_predictor
    import cpu_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         fetch_pc,
    output logic                predict_taken,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic                upd_taken,
    input  logic                upd_predicted,
    output logic                mispredict,
    output logic [CNT_BITS-1:0] branch_count,
    output logic [CNT_BITS-1:0] mispredict_count
);

    localparam int NENT = 1 << INDEX_BITS;

    logic [INDEX_BITS-1:0]  w_fidx;
    logic [INDEX_BITS-1:0]  w_uidx;
    logic [NENT-1:0][1:0]   w_cnt;
    logic                   w_miss;
    logic                   w_unused_pc;

    assign w_fidx = fetch_pc[INDEX_BITS+1:2];
    assign w_uidx = upd_pc[INDEX_BITS+1:2];
    assign w_miss = upd_valid && (upd_taken != upd_predicted);

    // Byte offset and tag bits are intentionally ignored (aliasing accepted).
    assign w_unused_pc = ^{fetch_pc[31:INDEX_BITS+2], fetch_pc[1:0],
                           upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};

    for (genvar i = 0; i < NENT; i++) begin : g_ent
        sat_counter2 u_cnt (
            .clk   (clk),
            .reset (reset),
            .we    (upd_valid && (w_uidx == INDEX_BITS'(i))),
            .taken (upd_taken),
            .cnt   (w_cnt[i])
        );
    end

    // Reads pre-update table state: no write-to-read bypass.
    assign predict_taken = w_cnt[w_fidx][1];

    logic                r_mispredict;
    logic [CNT_BITS-1:0] r_branch_cnt;
    logic [CNT_BITS-1:0] r_mis_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mispredict <= 1'b0;
            r_branch_cnt <= '0;
            r_mis_cnt    <= '0;
        end else begin
            r_mispredict <= w_miss;
            if (upd_valid) r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_miss)    r_mis_cnt    <= r_mis_cnt + 1'b1;
        end
    end

    assign mispredict       = r_mispredict;
    assign branch_count     = r_branch_cnt;
    assign mispredict_count = r_mis_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, saturation, hysteresis, no-bypass,
// aliasing, statistics wrap and mid-stream reset.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        predict_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_predicted;
    logic        mispredict;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    int errors = 0;
    int checks = 0;

    branch_predictor #(.INDEX_BITS(4), .CNT_BITS(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_pc         (fetch_pc),
        .predict_taken    (predict_taken),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_predicted    (upd_predicted),
        .mispredict       (mispredict),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic v, input logic [31:0] pc, input logic t, input logic p);
        upd_valid     = v;
        upd_pc        = pc;
        upd_taken     = t;
        upd_predicted = p;
    endtask

    initial begin
        fetch_pc = 32'h0;
        // Reset with a competing update that must be lost.
        reset = 1'b1;
        upd(1'b1, 32'h10, 1'b1, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        upd(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        for (int a = 0; a <= 32'h3C; a += 4) begin
            fetch_pc = a;
            #0.5;
            chk($sformatf("rst_pred_%0h", a), predict_taken, 1'b0);
        end
        chk("rst_bc", branch_count, 0);
        chk("rst_mc", mispredict_count, 0);
        chk("rst_mis", mispredict, 0);

        // Saturate up at index 4.
        tick();
        fetch_pc = 32'h10;
        upd(1'b1, 32'h10, 1'b1, 1'b0);
        #1;
        chk("up_pre", predict_taken, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("up_pred%0d", i), predict_taken, 1'b1);
            chk($sformatf("up_mis%0d", i), mispredict, 1'b1);
            chk($sformatf("up_bc%0d", i), branch_count, i + 1);
        end
        chk("up_mc", mispredict_count, 4);
        upd(1'b0, 32'h10, 1'b0, 1'b0);
        tick();
        chk("up_mis_drop", mispredict, 1'b0);
        chk("up_hold_bc", branch_count, 4);

        // Down: 11 -> 10 -> 01 -> 00 -> 00.
        upd(1'b1, 32'h10, 1'b0, 1'b1);
        tick(); chk("dn_10", predict_taken, 1'b1);
        tick(); chk("dn_01", predict_taken, 1'b0);
        tick(); chk("dn_00a", predict_taken, 1'b0);
        tick(); chk("dn_00b", predict_taken, 1'b0);
        chk("dn_bc", branch_count, 8);
        chk("dn_mc", mispredict_count, 8);
        // One taken from 00 only reaches 01 (stays not-taken).
        upd(1'b1, 32'h10, 1'b1, 1'b0);
        tick(); chk("dn_sat_low", predict_taken, 1'b0);

        // Same-cycle read/update with entry at 01: no bypass.
        upd(1'b1, 32'h10, 1'b1, 1'b1);
        #1;
        chk("byp_same", predict_taken, 1'b0);
        tick();
        chk("byp_next", predict_taken, 1'b1);
        chk("byp_mis", mispredict, 1'b0);
        chk("byp_bc", branch_count, 10);
        chk("byp_mc", mispredict_count, 9);

        // Aliasing: 0x50 and 0xFFFFFF53 both map to index 4.
        reset = 1'b1;
        upd(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        chk("al_rst", predict_taken, 1'b0);
        upd(1'b1, 32'h50, 1'b1, 1'b1);
        tick();
        upd(1'b1, 32'hFFFF_FF53, 1'b1, 1'b1);
        tick();
        upd(1'b0, 32'h0, 1'b0, 1'b0);
        fetch_pc = 32'h10; #1; chk("al_10", predict_taken, 1'b1);
        fetch_pc = 32'h13; #1; chk("al_13", predict_taken, 1'b1);
        fetch_pc = 32'h14; #1; chk("al_14", predict_taken, 1'b0);
        chk("al_bc", branch_count, 2);
        chk("al_mc", mispredict_count, 0);

        // Statistics wrap.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        upd(1'b1, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 65535; i++) begin
            upd_pc = i << 2;
            tick();
        end
        chk("wr_max", branch_count, 16'hFFFF);
        tick();
        chk("wr_zero", branch_count, 0);
        chk("wr_mc", mispredict_count, 0);
        chk("wr_mis", mispredict, 1'b0);

        // Mid-stream reset.
        fetch_pc = 32'h20;
        upd(1'b1, 32'h20, 1'b1, 1'b0);
        tick();
        tick();
        chk("ms_pre_pred", predict_taken, 1'b1);
        chk("ms_pre_mis", mispredict, 1'b1);
        reset = 1'b1;
        tick();
        chk("ms_pred", predict_taken, 1'b0);
        chk("ms_bc", branch_count, 0);
        chk("ms_mc", mispredict_count, 0);
        chk("ms_mis", mispredict, 1'b0);
        reset = 1'b0;
        // First post-reset update starts from 01: one not-taken gives 00.
        upd(1'b1, 32'h20, 1'b0, 1'b1);
        tick();
        chk("ms_first_pred", predict_taken, 1'b0);
        chk("ms_first_mis", mispredict, 1'b1);
        chk("ms_first_bc", branch_count, 1);
        upd(1'b1, 32'h20, 1'b1, 1'b0);
        tick();
        chk("ms_second_pred", predict_taken, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
